// File: rtl/eval_sequencer.sv
// Launches one board into the evaluator bank, gathers every eval_mg term
// and hands the signed total to the search core.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module eval_sequencer #(
  parameter int NUM_EVAL   = 4,
  parameter int EVAL_WIDTH = 24,
  parameter int OUT_WIDTH  = EVAL_WIDTH + $clog2(NUM_EVAL),
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [`BOARD_WIDTH-1:0]        board_in,
  input  logic [3:0]                     castle_mask_in,
  output logic [`BOARD_WIDTH-1:0]        board,
  output logic [3:0]                     castle_mask,
  output logic                           board_valid,
  output logic                           clear_eval,
  input  logic [NUM_EVAL-1:0]            eval_valid_in,
  input  logic [NUM_EVAL*EVAL_WIDTH-1:0] eval_mg_in,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic signed [OUT_WIDTH-1:0]    result,
  output logic                           timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, SUM, PRESENT, CLEAR
  } state_t;

  state_t state, state_nx;

  logic [NUM_EVAL-1:0]          done;
  logic [NUM_EVAL-1:0]          hit;
  logic [NUM_EVAL-1:0]          done_nx;
  logic                         all_done;
  logic                         expired;
  logic [CW-1:0]                cnt;
  logic signed [EVAL_WIDTH-1:0] terms [NUM_EVAL];
  logic signed [OUT_WIDTH-1:0]  sum;

  // A term is taken only on the first valid seen for that evaluator.
  assign hit      = eval_valid_in & ~done;
  assign done_nx  = done | hit;
  assign all_done = &done_nx;
  assign expired  = (cnt == LAST);

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_EVAL; i++) begin
      sum = sum + OUT_WIDTH'(terms[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    board_valid  = 1'b0;
    result_valid = 1'b0;
    clear_eval   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = reset;
        if (req_valid) state_nx = LAUNCH;
      end
      LAUNCH: begin
        board_valid = reset;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (all_done || expired) state_nx = SUM;
      end
      SUM: begin
        state_nx = PRESENT;
      end
      PRESENT: begin
        result_valid = reset;
        if (result_ready) state_nx = CLEAR;
      end
      CLEAR: begin
        clear_eval = reset;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      board       <= '0;
      castle_mask <= '0;
      done        <= '0;
      cnt         <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_EVAL; i++) terms[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            board       <= board_in;
            castle_mask <= castle_mask_in;
            done        <= '0;
            cnt         <= '0;
            for (int i = 0; i < NUM_EVAL; i++) terms[i] <= '0;
          end
        end
        WAIT: begin
          cnt  <= cnt + 1'b1;
          done <= done_nx;
          for (int i = 0; i < NUM_EVAL; i++) begin
            if (hit[i]) begin
              terms[i] <= eval_mg_in[i*EVAL_WIDTH +: EVAL_WIDTH];
            end
          end
          // Missing terms stay at zero and the sum goes ahead.
          if (!all_done && expired) timeout_err <= 1'b1;
        end
        SUM: begin
          result <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eval_sequencer.sv
// Directed bench for eval_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares whenever result_valid rises.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_eval_sequencer;

  localparam int NE = 4;
  localparam int EW = 24;
  localparam int OW = 26;

  typedef logic signed [EW-1:0] mg4_t [4];
  typedef int vc4_t [4];

  typedef struct {
    logic signed [OW-1:0] res;
    logic                 to;
    int                   lat;
    int                   clr;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic [`BOARD_WIDTH-1:0]  board_in = '0;
  logic [3:0]               castle_mask_in = '0;
  logic [`BOARD_WIDTH-1:0]  board;
  logic [3:0]               castle_mask;
  logic                     board_valid;
  logic                     clear_eval;
  logic [NE-1:0]            eval_valid_in = '0;
  logic [NE*EW-1:0]         eval_mg_in = '0;
  logic                     result_valid;
  logic                     result_ready = 1'b0;
  logic signed [OW-1:0]     result;
  logic                     timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  logic [`BOARD_WIDTH-1:0] exp_board = '0;
  logic [3:0]              exp_cm = '0;
  exp_t sbq [$];
  exp_t cur;
  bit   have = 0;
  bit   rv_q = 0;

  eval_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .board_in       (board_in),
    .castle_mask_in (castle_mask_in),
    .board          (board),
    .castle_mask    (castle_mask),
    .board_valid    (board_valid),
    .clear_eval     (clear_eval),
    .eval_valid_in  (eval_valid_in),
    .eval_mg_in     (eval_mg_in),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result         (result),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc - t0);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (board_valid) begin
        chk("board_valid_cycle", cyc - t0, 1);
        chk("board", longint'(board == exp_board), 1);
        chk("castle_mask", castle_mask, exp_cm);
      end
      if (result_valid && !rv_q) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          cur  = sbq.pop_front();
          have = 1;
          chk("result_latency", cyc - t0, cur.lat);
          chk("timeout_err", timeout_err, cur.to);
        end
      end
      if (result_valid && have) begin
        chk("result", result, cur.res);
        chk("req_ready_busy", req_ready, 0);
      end
      if (clear_eval) begin
        if (have) chk("clear_cycle", cyc - t0, cur.clr);
        else chk("unexpected_clear", 1, 0);
        have = 0;
      end
      rv_q = result_valid;
    end else begin
      rv_q = 0;
    end
  end

  task automatic drive_evals(input mg4_t a, input vc4_t vc,
                             input bit stale, input int rel);
    for (int i = 0; i < NE; i++) begin
      eval_valid_in[i] = stale || (rel >= vc[i]);
      if (rel < vc[i])
        eval_mg_in[i*EW +: EW] = a[i] ^ 24'h00F0F0;
      else if (rel == vc[i])
        eval_mg_in[i*EW +: EW] = a[i];
      else
        eval_mg_in[i*EW +: EW] = a[i] ^ 24'h5A5A5A;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_wait", 0, 1);
  endtask

  task automatic run_seq(input mg4_t a, input vc4_t vc, input int hold,
                         input bit stale, input logic signed [OW-1:0] exp,
                         input int lat, input bit to);
    int n = 0;
    int rvcnt = 0;
    bit done = 0;
    exp_t e;
    wait_ready();
    board_in       = {$urandom, $urandom};
    castle_mask_in = 4'($urandom);
    exp_board      = board_in;
    exp_cm         = castle_mask_in;
    t0             = cyc;
    e.res = exp;
    e.to  = to;
    e.lat = lat;
    e.clr = lat + hold + 1;
    sbq.push_back(e);
    req_valid = 1'b1;
    drive_evals(a, vc, stale, 0);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      drive_evals(a, vc, stale, cyc - t0);
      if (result_valid) begin
        result_ready = (rvcnt >= hold);
        req_valid    = (rvcnt < hold);
        rvcnt++;
      end else begin
        result_ready = 1'b0;
        req_valid    = 1'b0;
      end
      if (clear_eval) done = 1;
    end
    if (!done) chk("sequence_done", 0, 1);
    result_ready  = 1'b0;
    req_valid     = 1'b0;
    eval_valid_in = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_board_valid", board_valid, 0);
    chk("rst_result", result, 0);
    reset = 1'b1;
    #1;
    chk("rst_idle_ready", req_ready, 1);
    chk("rst_board", longint'(board == '0), 1);
    chk("rst_timeout", timeout_err, 0);

    run_seq('{24'sd100, -24'sd250, 24'sd37, 24'sd0}, '{8, 8, 8, 8},
            0, 0, -26'sd113, 10, 0);
    run_seq('{24'sd11, 24'sd22, 24'sd33, 24'sd44}, '{3, 5, 5, 9},
            0, 0, 26'sd110, 11, 0);
    run_seq('{24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000},
            '{4, 4, 4, 4}, 0, 0, 26'sh2000000, 6, 0);
    run_seq('{24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF},
            '{2, 3, 4, 5}, 0, 0, 26'sd33554428, 7, 0);
    run_seq('{24'sd1, 24'sd2, 24'sd3, 24'sd4}, '{6, 6, 6, 6},
            5, 0, 26'sd10, 8, 0);
    run_seq('{24'sd10, 24'sd20, 24'sd77, 24'sd30}, '{8, 8, 1000, 8},
            0, 0, 26'sd60, 67, 1);
    run_seq('{-24'sd5, -24'sd6, -24'sd7, -24'sd8}, '{4, 4, 4, 4},
            0, 0, -26'sd26, 6, 1);

    wait_ready();
    board_in       = {$urandom, $urandom};
    castle_mask_in = 4'hF;
    exp_board      = board_in;
    exp_cm         = castle_mask_in;
    t0             = cyc;
    req_valid      = 1'b1;
    @(negedge clk);
    req_valid     = 1'b0;
    eval_valid_in = 4'b0111;
    eval_mg_in    = {4{24'sd9}};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready, 0);
    @(negedge clk);
    eval_valid_in = 4'hF;
    chk("midrst_board", longint'(board == '0), 1);
    chk("midrst_castle", castle_mask, 0);
    chk("midrst_result", result, 0);
    chk("midrst_result_valid", result_valid, 0);
    chk("midrst_clear", clear_eval, 0);
    chk("midrst_timeout", timeout_err, 0);
    reset = 1'b1;
    #1;
    chk("midrst_idle", req_ready, 1);
    repeat (2) @(negedge clk);
    chk("midrst_no_launch", board_valid, 0);

    run_seq('{24'sd1000, -24'sd1, 24'sd5, -24'sd4}, '{2, 2, 2, 2},
            0, 1, 26'sd1000, 4, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
